dot_product_mac: RTL

Datapath stage directly downstream of the dot-product control unit. Consumes the controller's `we`/`addr`/`done` strobes together with two signed element streams. Computes the signed dot product of one vector pair per run through a two-stage multiply-accumulate pipeline, then publishes the result with a one-cycle valid pulse and an element-count check. Feeds the sorter's distance/score path.

---
 rtl/dot_product_pkg.sv | 30 +++
 rtl/dot_product_mac_if.sv | 30 +++
 rtl/dp_mult_stage.sv | 55 +++++
 rtl/dot_product_mac.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Purpose: shared widths and signed datapath types for the dot-product MAC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: element/product/accumulator typedefs, element counter type,
// and a sign-extension helper that widens a product to accumulator width.
package dot_product_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 3;
    // Must not exceed 2**ADDR_WIDTH; the accumulator headroom assumes it.
    localparam int VEC_LEN    = 4;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef logic signed [PROD_WIDTH-1:0] prod_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic        [CNT_WIDTH-1:0]  cnt_t;

    localparam cnt_t CNT_MAX   = '1;
    localparam cnt_t VEC_LEN_C = cnt_t'(VEC_LEN);

    // Both types are signed, so the cast replicates the product's sign bit.
    function automatic acc_t sext_prod(input prod_t p);
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// Purpose: bundles the controller strobes, element streams and result outputs.
// Latency: n/a (wires only).
// Backpressure: none; the MAC consumes every accepted element.
//
// master: controller side (drives we/addr/done/a_in/b_in, observes results).
// slave:  MAC side (consumes strobes and elements, drives result/status).
interface dot_product_mac_if;
    import dot_product_pkg::*;

    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  done;
    elem_t                 a_in;
    elem_t                 b_in;
    acc_t                  result;
    logic                  result_valid;
    logic                  count_err;
    logic                  busy;

    modport master (
        output we, addr, done, a_in, b_in,
        input  result, result_valid, count_err, busy
    );

    modport slave (
        input  we, addr, done, a_in, b_in,
        output result, result_valid, count_err, busy
    );

endinterface

// File: rtl/dp_mult_stage.sv
// Purpose: stage-1 product register tagged with valid and first-element flags.
// Latency: 1 cycle from accept to registered product.
// Backpressure: none; a new product is captured on every accept.
//
// Ports: clk, rst (async active-low), accept_i/first_i tags, a_i/b_i signed
// elements in; prod_o, valid_o, first_o registered out.
module dp_mult_stage
    import dot_product_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  accept_i,
    input  logic  first_i,
    input  elem_t a_i,
    input  elem_t b_i,
    output prod_t prod_o,
    output logic  valid_o,
    output logic  first_o
);

    prod_t prod_q, prod_d;
    logic  valid_q, valid_d;
    logic  first_q, first_d;
    prod_t a_ext, b_ext;

    // Widen before multiplying so the product is computed at full width.
    assign a_ext = prod_t'(a_i);
    assign b_ext = prod_t'(b_i);

    always_comb begin
        prod_d  = prod_q;
        valid_d = accept_i;
        first_d = accept_i & first_i;
        if (accept_i) begin
            prod_d = a_ext * b_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign prod_o  = prod_q;
    assign valid_o = valid_q;
    assign first_o = first_q;

endmodule

// File: rtl/dot_product_mac.sv
// Purpose: signed dot product of one vector pair per run, with element-count check.
// Latency: result/result_valid visible 3 cycles after the last accepted element.
// Backpressure: none; every we=1 && done=0 cycle is consumed.
//
// Ports: clk, rst (async active-low), bus (slave side of dot_product_mac_if):
// we/addr/done strobes and a_in/b_in elements in; result, result_valid,
// count_err, busy out.
module dot_product_mac
    import dot_product_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dot_product_mac_if.slave  bus
);

    logic  accept;
    logic  first_now;
    prod_t p_prod;
    logic  p_valid;
    logic  p_first;

    logic  done_d1_q;
    logic  armed_q,   armed_d;
    cnt_t  cnt_q,     cnt_d;
    acc_t  acc_q,     acc_d;
    acc_t  result_q,  result_d;
    logic  res_vld_q, res_vld_d;
    logic  cnt_err_q, cnt_err_d;

    // The element index is informational only; first-element detection uses
    // the armed flag instead.
    logic  addr_unused;
    assign addr_unused = ^bus.addr;

    // A done cycle never carries an element, even with we high.
    assign accept = bus.we & ~bus.done;

    // The cycle right after done already belongs to the next vector, so an
    // accept there must be tagged first even though armed_q re-arms only at
    // the end of that cycle.
    assign first_now = armed_q | done_d1_q;

    dp_mult_stage u_mult (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept),
        .first_i  (first_now),
        .a_i      (bus.a_in),
        .b_i      (bus.b_in),
        .prod_o   (p_prod),
        .valid_o  (p_valid),
        .first_o  (p_first)
    );

    always_comb begin
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        cnt_err_d = cnt_err_q;
        res_vld_d = 1'b0;

        // First-element flag: consumed by an accept, re-armed by end of vector.
        if (accept) begin
            armed_d = 1'b0;
        end else if (done_d1_q) begin
            armed_d = 1'b1;
        end

        // Element counter: a first accept restarts it, later ones saturate.
        if (accept) begin
            if (first_now) begin
                cnt_d = cnt_t'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end

        // Stage 2: the first product of a vector overwrites the running sum.
        if (p_valid) begin
            if (p_first) begin
                acc_d = sext_prod(p_prod);
            end else begin
                acc_d = acc_q + sext_prod(p_prod);
            end
        end

        // End of vector. armed_q still high here means nothing was accepted
        // since the previous end of vector, so acc/cnt are stale.
        if (done_d1_q) begin
            res_vld_d = 1'b1;
            if (armed_q) begin
                result_d  = '0;
                cnt_err_d = 1'b1;
            end else begin
                result_d  = acc_q;
                cnt_err_d = (cnt_q != VEC_LEN_C);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_d1_q <= 1'b0;
            armed_q   <= 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            res_vld_q <= 1'b0;
            cnt_err_q <= 1'b0;
        end else begin
            done_d1_q <= bus.done;
            armed_q   <= armed_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            res_vld_q <= res_vld_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = res_vld_q;
    assign bus.count_err    = cnt_err_q;
    assign bus.busy         = p_valid | done_d1_q;

endmodule
